fcvt_int_to_float: RTL and testbench

Multi-cycle integer-to-floating-point converter for the FPU (FCVT.S.W/WU, FCVT.D.L/LU), the reverse path of the float-to-integer-result units such as the equality comparator. It accepts a signed or unsigned integer of BUS_WIDTH bits. It normalises the integer with a one-bit-per-cycle shifter, rounds to nearest-even, and returns an IEEE-754 value of the same width with an inexact flag. The block sits beside the combinational FPU ops and handshakes with the execute stage via start/busy/valid.

---
 rtl/fcvt_int_to_float_pkg.sv | 13 +
 rtl/fcvt_int_to_float_round.sv | 26 ++
 rtl/fcvt_int_to_float.sv | 70 +++++++
 tb/tb_fcvt_int_to_float.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/fcvt_int_to_float_pkg.sv
// fcvt_int_to_float_pkg: shared FPU format sizing and converter state encoding
package fcvt_int_to_float_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, NORM = 2'd1, ROUND = 2'd2} state_t;
  function automatic int mant_size(input int w);
    return (w == 32) ? 23 : 52;
  endfunction
  function automatic int exp_size(input int w);
    return (w == 32) ? 8 : 11;
  endfunction
  function automatic int bias(input int w);
    return (1 << (exp_size(w) - 1)) - 1;
  endfunction
endpackage

// File: rtl/fcvt_int_to_float_round.sv
// fcvt_int_to_float_round: RNE rounding of a normalised magnitude into a packed IEEE-754 value
module fcvt_int_to_float_round
  import fcvt_int_to_float_pkg::*;
#(
  parameter int W = 64,
  parameter int E = exp_size(W)
) (
  input  logic [W-2:0] mag,
  input  logic [E-1:0] expo,
  input  logic         sign,
  output logic [W-1:0] res,
  output logic         nx
);
  localparam int M = mant_size(W);
  logic [M-1:0] frac;
  logic [M:0]   sum;
  logic         guard, sticky, up;
  assign frac   = mag[W-2 -: M];
  assign guard  = mag[W-2-M];
  assign sticky = |mag[W-3-M:0];
  assign up     = guard & (sticky | frac[0]);
  assign sum    = {1'b0, frac} + (M+1)'(up);
  // a mantissa carry leaves sum[M-1:0] at zero, so only the exponent moves
  assign res    = {sign, expo + E'(sum[M]), sum[M-1:0]};
  assign nx     = guard | sticky;
endmodule

// File: rtl/fcvt_int_to_float.sv
// fcvt_int_to_float: multi-cycle signed/unsigned integer to IEEE-754 converter, RNE
module fcvt_int_to_float
  import fcvt_int_to_float_pkg::*;
#(
  parameter int BUS_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_unsigned,
  input  logic [BUS_WIDTH-1:0] in,
  output logic                 busy,
  output logic                 valid,
  output logic [BUS_WIDTH-1:0] out,
  output logic                 nx
);
  localparam int W = BUS_WIDTH;
  localparam int E = exp_size(W);
  state_t         state, state_n;
  logic [W-1:0]   mag, res;
  logic [E-1:0]   exp_q;
  logic           sign, rnx, neg;
  assign busy = (state != IDLE);
  assign neg  = ~is_unsigned & in[W-1];
  always_comb begin
    state_n = (state == IDLE) ? (start ? NORM : IDLE) :
              (state == NORM) ? ((mag == '0) ? IDLE : mag[W-1] ? ROUND : NORM) :
              IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end
  // negating the signed minimum wraps to 2^(W-1), which is the correct unsigned magnitude
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      sign  <= neg;
      mag   <= neg ? -in : in;
      exp_q <= E'(bias(W) + W - 1);
    end else if (state == NORM && mag != '0 && !mag[W-1]) begin
      mag   <= mag << 1;
      exp_q <= exp_q - 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      out   <= '0;
      nx    <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (state == NORM && mag == '0) begin
        valid <= 1'b1;
        out   <= '0;
        nx    <= 1'b0;
      end else if (state == ROUND) begin
        valid <= 1'b1;
        out   <= res;
        nx    <= rnx;
      end
    end
  end
  fcvt_int_to_float_round #(.W(W), .E(E)) u_round (
    .mag  (mag[W-2:0]),
    .expo (exp_q),
    .sign (sign),
    .res  (res),
    .nx   (rnx)
  );
endmodule

// File: tb/tb_fcvt_int_to_float.sv
// tb_fcvt_int_to_float: directed and random checks of 64- and 32-bit converters against an arithmetic model
module tb_fcvt_int_to_float;
  logic        clk = 1'b0, rst = 1'b1;
  logic        st64 = 1'b0, un64 = 1'b0, st32 = 1'b0, un32 = 1'b0;
  logic [63:0] in64 = '0, o64;
  logic [31:0] in32 = '0, o32;
  logic        b64, v64, nx64, b32, v32, nx32;
  int          cmp = 0, mis = 0;
  logic [63:0] last_out;
  logic        last_nx;

  fcvt_int_to_float #(.BUS_WIDTH(64)) dut64 (
    .clk(clk), .rst(rst), .start(st64), .is_unsigned(un64), .in(in64),
    .busy(b64), .valid(v64), .out(o64), .nx(nx64));
  fcvt_int_to_float #(.BUS_WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(st32), .is_unsigned(un32), .in(in32),
    .busy(b32), .valid(v32), .out(o32), .nx(nx32));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    cmp++;
    assert (obs === exp_v) else begin
      mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic busy_of(input int w);
    return (w == 64) ? b64 : b32;
  endfunction
  function automatic logic valid_of(input int w);
    return (w == 64) ? v64 : v32;
  endfunction

  // Reference: locate the top set bit, then round the truncated quotient by comparing the remainder with half an ulp.
  function automatic void model(input logic [63:0] val, input bit uns, input int w,
                                output logic [63:0] res, output logic enx, output int lat);
    logic [63:0] mask, mag, q, rem, half;
    int p, m, bs, sh;
    bit neg;
    longint unsigned e;
    m    = (w == 64) ? 52 : 23;
    bs   = (w == 64) ? 1023 : 127;
    mask = (w == 64) ? '1 : (64'd1 << w) - 64'd1;
    neg  = !uns && val[w-1];
    mag  = neg ? ((~val + 64'd1) & mask) : (val & mask);
    res = '0; enx = 1'b0; lat = 1;
    if (mag == 64'd0) return;
    p = 0;
    for (int i = 0; i < w; i++) if (mag[i]) p = i;
    lat = w - 1 - p + 2;
    e = longint'(bs + p);
    rem = 64'd0;
    if (p <= m) q = mag << (m - p);
    else begin
      sh   = p - m;
      q    = mag >> sh;
      rem  = mag & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      if (q == (64'd1 << (m + 1))) begin q = q >> 1; e = e + 1; end
    end
    enx = (rem != 64'd0);
    res = ({63'd0, neg} << (w - 1)) | (64'(e) << m) | (q & ((64'd1 << m) - 64'd1));
  endfunction

  task automatic drive(input int w, input logic s, input logic [63:0] val, input bit uns);
    if (w == 64) begin st64 = s; in64 = val; un64 = uns; end
    else begin st32 = s; in32 = val[31:0]; un32 = uns; end
  endtask

  task automatic run(input int w, input logic [63:0] val, input bit uns, input bit b2b, input bit noise);
    logic [63:0] eres;
    logic        enx;
    int          elat, n;
    bit          busy_ok;
    if (!b2b) @(negedge clk);
    model(val, uns, w, eres, enx, elat);
    chk("busy_before_start", busy_of(w), 0);
    drive(w, 1'b1, val, uns);
    @(posedge clk);
    #1;
    drive(w, 1'b0, 64'd0, 1'b0);
    busy_ok = busy_of(w);
    n = 0;
    do begin
      if (noise) drive(w, 1'b1, {$urandom, $urandom}, 1'($urandom));
      @(posedge clk);
      #1;
      drive(w, 1'b0, 64'd0, 1'b0);
      n++;
      if (!valid_of(w) && !busy_of(w)) busy_ok = 1'b0;
    end while (!valid_of(w) && n < w + 4);
    chk("valid_seen", valid_of(w), 1);
    chk("latency", 64'(n), 64'(elat));
    chk("busy_while_running", busy_ok, 1);
    chk("busy_at_valid", busy_of(w), 0);
    last_out = (w == 64) ? o64 : {32'd0, o32};
    last_nx  = (w == 64) ? nx64 : nx32;
    chk("out_model", last_out, eres);
    chk("nx_model", last_nx, enx);
  endtask

  initial begin
    bit stale;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy64", b64, 0); chk("rst_valid64", v64, 0);
    chk("rst_out64", o64, 0);  chk("rst_nx64", nx64, 0);
    chk("rst_busy32", b32, 0); chk("rst_out32", 64'(o32), 0);
    @(negedge clk) rst = 1'b0;

    run(64, 64'd1, 0, 0, 0);
    chk("one", last_out, 64'h3FF0000000000000); chk("one_nx", last_nx, 0);
    run(64, 64'hFFFFFFFFFFFFFFFF, 0, 0, 0);
    chk("minus_one", last_out, 64'hBFF0000000000000);
    run(64, 64'h8000000000000000, 0, 0, 0);
    chk("smin", last_out, 64'hC3E0000000000000);
    run(64, 64'd0, 0, 0, 0);
    chk("zero", last_out, 64'd0); chk("zero_nx", last_nx, 0);
    run(64, 64'h0020000000000001, 0, 0, 0);
    chk("tie_even_down", last_out, 64'h4340000000000000); chk("tie_down_nx", last_nx, 1);
    run(64, 64'h0020000000000003, 0, 0, 0);
    chk("tie_up", last_out, 64'h4340000000000002); chk("tie_up_nx", last_nx, 1);
    run(64, 64'hFFFFFFFFFFFFFFFF, 1, 0, 0);
    chk("u_max_carry", last_out, 64'h43F0000000000000); chk("u_max_nx", last_nx, 1);
    run(32, 64'd7, 0, 0, 0);
    chk("s32_seven", last_out, 64'h40E00000);
    run(32, 64'h80000001, 1, 0, 0);
    chk("u32_round", last_out, 64'h4F000000); chk("u32_nx", last_nx, 1);

    run(64, 64'd1, 0, 0, 1);
    chk("ignored_start", last_out, 64'h3FF0000000000000);
    run(64, 64'h0020000000000003, 0, 1, 0);
    chk("b2b_accept", last_out, 64'h4340000000000002);

    for (int i = 0; i < 16; i++) run(64, {$urandom, $urandom} >> $urandom_range(0, 63), 1'($urandom), 0, 0);
    for (int i = 0; i < 12; i++) run(32, 64'({$urandom} >> $urandom_range(0, 31)), 1'($urandom), 0, 0);

    run(64, 64'hFFFFFFFFFFFFFFFF, 0, 0, 0);
    @(negedge clk);
    drive(64, 1'b1, 64'd1, 1'b0);
    @(posedge clk);
    #1;
    drive(64, 1'b0, 64'd0, 1'b0);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", b64, 0); chk("abort_valid", v64, 0);
    chk("abort_out", o64, 0);  chk("abort_nx", nx64, 0);
    @(negedge clk) rst = 1'b0;
    stale = 1'b0;
    repeat (80) begin @(posedge clk); #1; if (v64) stale = 1'b1; end
    chk("no_stale_valid", stale, 0);
    run(64, 64'd7, 0, 0, 0);
    chk("after_abort", last_out, 64'h401C000000000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end
endmodule
